// File: rtl/bcp_var_table.sv
// bcp_var_table
//   Single-port scratch table for the BCP engine. Holds 2**address_width words
//   of var_num bits (one bit per variable), with a registered read port.
//
// Ports
//   clock    in   system clock, all state changes on the rising edge
//   reset    in   synchronous active-low reset, clears every entry and dout
//   en       in   access enable; low means idle (table and dout hold)
//   r_w      in   1 = read, 0 = write
//   address  in   entry select
//   din      in   write data
//   dout     out  registered read data, held between reads
module bcp_var_table #(
  parameter int address_width = 3,
  parameter int var_num       = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     r_w,
  input  logic [address_width-1:0] address,
  input  logic [var_num-1:0]       din,
  output logic [var_num-1:0]       dout
);

  localparam int depth = 1 << address_width;

  // The table is built from flops rather than a RAM macro because reset must
  // clear every entry in a single edge.
  logic [var_num-1:0] mem_q [depth];
  logic [var_num-1:0] mem_d [depth];
  logic [var_num-1:0] dout_q;
  logic [var_num-1:0] dout_d;

  always_comb begin
    mem_d  = mem_q;
    dout_d = dout_q;
    if (en) begin
      if (r_w) begin
        dout_d = mem_q[address];
      end else begin
        // dout is left alone on writes: no write-through.
        mem_d[address] = din;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
      dout_q <= '0;
    end else begin
      mem_q  <= mem_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_bcp_var_table.sv
module tb_bcp_var_table;

  logic       clock;
  logic       reset;
  logic       en;
  logic       r_w;
  logic [2:0] address;
  logic [7:0] din;
  logic [7:0] dout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Behavioural reference: plain array plus the last value read out.
  logic [7:0] ref_mem [8];
  logic [7:0] ref_dout;
  bit         ref_valid = 0;

  bcp_var_table #(.address_width(3), .var_num(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .r_w     (r_w),
    .address (address),
    .din     (din),
    .dout    (dout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) ref_mem[i] = 8'h00;
      ref_dout  = 8'h00;
      ref_valid = 1'b1;
    end else if (en) begin
      if (r_w) ref_dout = ref_mem[address];
      else     ref_mem[address] = din;
    end
  end

  always @(negedge clock) begin
    if (ref_valid) begin
      total_cnt++;
      if (dout === ref_dout) pass_cnt++;
      else $display("FAIL model_cmp t=%0t dout=%h expected=%h", $time, dout, ref_dout);
    end
  end

  task automatic step(input logic rst, input logic e, input logic rw,
                      input logic [2:0] a, input logic [7:0] d);
    reset   = rst;
    en      = e;
    r_w     = rw;
    address = a;
    din     = d;
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [7:0] exp);
    total_cnt++;
    if (dout === exp) pass_cnt++;
    else $display("FAIL %s dout=%h expected=%h", name, dout, exp);
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; r_w = 1'b0; address = '0; din = '0;

    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 0, 3, 8'h77);
    chk("reset_dout", 8'h00);

    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 3'(i), 8'hAA);
      chk("reset_read", 8'h00);
    end

    step(1, 1, 0, 0, 8'hE0);
    step(1, 1, 0, 1, 8'h90);
    step(1, 1, 0, 2, 8'h48);
    step(1, 1, 1, 0, 8'h00); chk("read_addr0", 8'hE0);
    step(1, 1, 1, 1, 8'h00); chk("read_addr1", 8'h90);
    step(1, 1, 1, 2, 8'h00); chk("read_addr2", 8'h48);

    step(1, 1, 1, 1, 8'h00); chk("hold_pre", 8'h90);
    step(1, 1, 0, 3, 8'hFF); chk("hold_during_write", 8'h90);
    step(1, 1, 1, 3, 8'h00); chk("read_addr3", 8'hFF);

    step(1, 0, 0, 0, 8'h55); chk("idle_write_dout", 8'hFF);
    step(1, 1, 1, 0, 8'h00); chk("idle_write_mem", 8'hE0);
    step(1, 0, 1, 1, 8'h00); chk("idle_read_dout", 8'hE0);

    step(1, 1, 0, 7, 8'hA5); chk("raw_write_dout", 8'hE0);
    step(1, 1, 1, 7, 8'h00); chk("raw_read", 8'hA5);

    step(0, 1, 0, 2, 8'h3C); chk("midreset_dout", 8'h00);
    for (int i = 0; i < 8; i++) begin
      step(1, 1, 1, 3'(i), 8'h00);
      chk("post_reset_read", 8'h00);
    end

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 63) != 0), $urandom_range(0, 3) != 0,
           1'($urandom), 3'($urandom), 8'($urandom));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
